// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back slice.
//   XLEN       : data width of register values
//   REG_ADDR_W : register address width (32 architectural registers)
//   NUM_REGS   : number of architectural registers
//   wb_entry_t : one buffered write-back result {rd, data}
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order buffer for load results awaiting the register-file write port.
// Ports:
//   CLK, reset  : posedge clock, asynchronous active-high reset (empties the buffer)
//   push        : store push_entry at the tail (ignored when full)
//   push_entry  : entry to store
//   pop         : drop the head entry (ignored when empty)
//   head        : current head entry (valid when !empty)
//   full, empty : occupancy flags
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit so
// full and empty can be told apart when the index bits are equal.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      CLK,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  wb_entry_t      mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: nothing is read until a push has written it.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side companion of the 32x32 register file. Merges ALU and LSU results
// onto the single register-file write port and tracks registers waiting for
// long-latency (load) results so decode can stall on RAW/WAW hazards.
// Ports:
//   CLK, reset            : posedge clock, asynchronous active-high reset
//   alu_valid/rd/data     : ALU result, no backpressure, highest priority
//   lsu_valid/ready/rd/data : load result, accepted when lsu_valid && lsu_ready
//   iss_valid/rd, iss_ready : long-latency issue; ready low on WAW with a pending rd
//   rs1, rs2              : decode source addresses
//   rs1_busy, rs2_busy    : source is waiting for a load result
//   fwd1_*/fwd2_*         : same-cycle forwarding of the popping load result
//   WE3, A3, WD3          : registered register-file write port
// Handshake: an LSU result transfers on a posedge where lsu_valid && lsu_ready;
//   lsu_ready is simply !full (a pop in the same cycle does not free a slot early).
//   An issue is recorded on a posedge where iss_valid && iss_ready.
// Build option: define WB_BYPASS_EN to forward the popping load result to
//   decode in the same cycle; otherwise fwd outputs are tied to zero.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  fwd1_valid,
  output logic [XLEN-1:0]       fwd1_data,
  output logic                  fwd2_valid,
  output logic [XLEN-1:0]       fwd2_data,
  output logic                  WE3,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3
);

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  wb_entry_t     fifo_head;
  wb_entry_t     push_entry;

  logic          alu_wr;
  logic          iss_fire;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // ALU writes to x0 are dropped and do not block the LSU path.
  assign alu_wr    = alu_valid && (alu_rd != '0);
  assign lsu_ready = !fifo_full;
  // Loads to x0 are accepted but never stored.
  assign fifo_push = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign fifo_pop  = !alu_wr && !fifo_empty;
  assign push_entry = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Scoreboard.
  assign iss_ready = (iss_rd == '0) || !pending_q[iss_rd];
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

  always_comb begin
    pending_d = pending_q;
    if (fifo_pop) pending_d[fifo_head.rd] = 1'b0;
    // Applied after the clear so a same-cycle issue to the popping rd stays pending.
    if (iss_fire) pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Decode-side hazard view.
  logic rs1_pend;
  logic rs2_pend;

  assign rs1_pend = (rs1 != '0) && pending_q[rs1];
  assign rs2_pend = (rs2 != '0) && pending_q[rs2];

`ifdef WB_BYPASS_EN
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = fifo_pop && (rs1 != '0) && (fifo_head.rd == rs1);
  assign rs2_hit = fifo_pop && (rs2 != '0) && (fifo_head.rd == rs2);

  always_comb begin
    rs1_busy   = rs1_pend && !rs1_hit;
    rs2_busy   = rs2_pend && !rs2_hit;
    fwd1_valid = rs1_hit;
    fwd2_valid = rs2_hit;
    fwd1_data  = rs1_hit ? fifo_head.data : '0;
    fwd2_data  = rs2_hit ? fifo_head.data : '0;
  end
`else
  always_comb begin
    rs1_busy   = rs1_pend;
    rs2_busy   = rs2_pend;
    fwd1_valid = 1'b0;
    fwd2_valid = 1'b0;
    fwd1_data  = '0;
    fwd2_data  = '0;
  end
`endif

  // Registered write port: stable across the register file's negedge write.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else if (alu_wr) begin
      WE3 <= 1'b1;
      A3  <= alu_rd;
      WD3 <= alu_data;
    end else if (fifo_pop) begin
      WE3 <= 1'b1;
      A3  <= fifo_head.rd;
      WD3 <= fifo_head.data;
    end else begin
      WE3 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  import regfile_pkg::*;

  logic                  CLK;
  logic                  reset;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_data;
  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic                  iss_ready;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  fwd1_valid;
  logic [XLEN-1:0]       fwd1_data;
  logic                  fwd2_valid;
  logic [XLEN-1:0]       fwd2_data;
  logic                  WE3;
  logic [REG_ADDR_W-1:0] A3;
  logic [XLEN-1:0]       WD3;

  int n_checks = 0;
  int n_errors = 0;

  logic [XLEN-1:0] rf [NUM_REGS];

  regfile_writeback #(.LSU_FIFO_DEPTH(2)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .fwd1_valid (fwd1_valid),
    .fwd1_data  (fwd1_data),
    .fwd2_valid (fwd2_valid),
    .fwd2_data  (fwd2_data),
    .WE3        (WE3),
    .A3         (A3),
    .WD3        (WD3)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register-file model: writes on the negedge from the registered port.
  initial for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
  always @(negedge CLK) if (WE3 && A3 != '0) rf[A3] <= WD3;

  // Checking
  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [XLEN-1:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [XLEN-1:0] d);
    lsu_valid = 1'b1; lsu_rd = rd; lsu_data = d;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] a, input logic [XLEN-1:0] d);
    check({tag, "_we"}, XLEN'(WE3), XLEN'(we));
    check({tag, "_a3"}, XLEN'(A3), XLEN'(a));
    check({tag, "_wd"}, WD3, d);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #12;
    check("rst_we3", XLEN'(WE3), 0);
    check("rst_a3", XLEN'(A3), 0);
    check("rst_wd3", WD3, 0);
    check("rst_lsu_ready", XLEN'(lsu_ready), 1);
    check("rst_iss_ready", XLEN'(iss_ready), 1);
    check("rst_fwd1", XLEN'(fwd1_valid), 0);
    reset = 1'b0;
    step();

    // 1. Reset mid-stream with FIFO full and pending[5]
    alu(5'd1, 32'h1); lsu(5'd8, 32'h88); iss_valid = 1'b1; iss_rd = 5'd5;
    step();
    iss_valid = 1'b0; lsu(5'd9, 32'h99);
    step();
    idle(); rs1 = 5'd5; #1;
    check("t1_full_ready", XLEN'(lsu_ready), 0);
    check("t1_busy5", XLEN'(rs1_busy), 1);
    reset = 1'b1; #1;
    check("t1_async_we3", XLEN'(WE3), 0);
    check("t1_async_ready", XLEN'(lsu_ready), 1);
    check("t1_async_busy5", XLEN'(rs1_busy), 0);
    #1 reset = 1'b0;
    step();
    check("t1_after_we3", XLEN'(WE3), 0);
    check("t1_after_ready", XLEN'(lsu_ready), 1);
    check("t1_after_busy5", XLEN'(rs1_busy), 0);

    // 2. ALU write, one-cycle latency
    alu(5'd3, 32'hDEADBEEF);
    step();
    check_wr("t2", 1'b1, 5'd3, 32'hDEADBEEF);
    idle();
    step();
    check("t2_idle_we3", XLEN'(WE3), 0);
    check("t2_x3", rf[3], 32'hDEADBEEF);

    // 3/6. Issue rd=7, load returns with competing ALU write to x2
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0; rs1 = 5'd7; #1;
    check("t3_iss_block", XLEN'(iss_ready), 0);
    check("t3_busy7", XLEN'(rs1_busy), 1);
    alu(5'd2, 32'h2222); lsu(5'd7, 32'h1234); #1;
    check("t3_lsu_ready", XLEN'(lsu_ready), 1);
    step();
    check_wr("t3_alu_first", 1'b1, 5'd2, 32'h2222);
    alu_valid = 1'b0; lsu_valid = 1'b0; #1;
    check("t3_iss_block_pop", XLEN'(iss_ready), 0);
`ifdef WB_BYPASS_EN
    check("t6_busy_bypass", XLEN'(rs1_busy), 0);
    check("t6_fwd_valid", XLEN'(fwd1_valid), 1);
    check("t6_fwd_data", fwd1_data, 32'h1234);
`else
    check("t6_busy_nobypass", XLEN'(rs1_busy), 1);
    check("t6_fwd_valid", XLEN'(fwd1_valid), 0);
    check("t6_fwd_data", fwd1_data, 0);
`endif
    step();
    check_wr("t3_load", 1'b1, 5'd7, 32'h1234);
    check("t3_busy7_clear", XLEN'(rs1_busy), 0);
    check("t3_iss_free", XLEN'(iss_ready), 1);
    idle();
    step();
    check("t3_x2", rf[2], 32'h2222);
    check("t3_x7", rf[7], 32'h1234);

    // 4. Three back-to-back loads under continuous ALU traffic
    alu(5'd10, 32'hA0); lsu(5'd11, 32'hB); #1;
    check("t4_ready0", XLEN'(lsu_ready), 1);
    step();
    alu(5'd10, 32'hA1); lsu(5'd12, 32'hC); #1;
    check("t4_ready1", XLEN'(lsu_ready), 1);
    step();
    alu(5'd10, 32'hA2); lsu(5'd13, 32'hD); #1;
    check("t4_full", XLEN'(lsu_ready), 0);
    step();
    check_wr("t4_alu", 1'b1, 5'd10, 32'hA2);
    alu_valid = 1'b0; #1;
    check("t4_no_passthru", XLEN'(lsu_ready), 0);
    step();
    check_wr("t4_pop11", 1'b1, 5'd11, 32'hB);
    check("t4_ready_again", XLEN'(lsu_ready), 1);
    step();
    check_wr("t4_pop12", 1'b1, 5'd12, 32'hC);
    lsu_valid = 1'b0;
    step();
    check_wr("t4_pop13", 1'b1, 5'd13, 32'hD);
    step();
    check_wr("t4_hold", 1'b0, 5'd13, 32'hD);

    // 5. x0 destinations
    alu(5'd0, 32'h55); lsu(5'd0, 32'h66); iss_valid = 1'b1; iss_rd = 5'd0; #1;
    check("t5_iss_x0", XLEN'(iss_ready), 1);
    step();
    check_wr("t5_x0_a", 1'b0, 5'd13, 32'hD);
    idle();
    step();
    check_wr("t5_x0_b", 1'b0, 5'd13, 32'hD);
    check("t5_busy_x0", XLEN'(rs1_busy), 0);
    alu(5'd0, 32'h77); lsu(5'd4, 32'h44);
    step();
    check("t5_alu0_we3", XLEN'(WE3), 0);
    lsu_valid = 1'b0;
    step();
    check_wr("t5_pop_past_alu0", 1'b1, 5'd4, 32'h44);

    // Same-cycle issue and pop of one rd: the issue wins
    idle(); lsu(5'd20, 32'h20);
    step();
    idle(); iss_valid = 1'b1; iss_rd = 5'd20;
    step();
    check_wr("t7_pop20", 1'b1, 5'd20, 32'h20);
    idle(); rs2 = 5'd20; #1;
    check("t7_set_wins", XLEN'(rs2_busy), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
